// File: rtl/rs_slot_tracker_pkg.sv
// Shared sizing and types for the reservation-station slot tracker.
package rs_slot_tracker_pkg;
    localparam int RS_SIZE = 32;
    localparam int IDX_W   = $clog2(RS_SIZE);
    localparam int CNT_W   = $clog2(RS_SIZE + 1);

    typedef logic [IDX_W-1:0]   rs_idx_t;
    typedef logic [RS_SIZE-1:0] rs_mask_t;
    typedef logic [CNT_W-1:0]   rs_cnt_t;
endpackage

// File: rtl/rs_slot_tracker_binary_to_onehot.sv
// Combinational binary-index to one-hot slot decoder; exact inverse of onehot_to_binary_RS.
module binary_to_onehot_RS #(
    parameter int N = 32,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] bin,
    output logic [N-1:0]     oh,
    output logic             in_range
);
    assign in_range = (32'(bin) < N);

    // An out-of-range index decodes to an all-zero mask.
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign oh[gi] = in_range && (32'(bin) == gi);
    end
endmodule

// File: rtl/rs_slot_tracker.sv
// RS occupancy bitmap: decodes alloc/free indices, applies only legal ops, tracks count and a sticky error.
module rs_slot_tracker
    import rs_slot_tracker_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               alloc_en,
    input  logic [IDX_W-1:0]   alloc_idx,
    input  logic               free_en,
    input  logic [IDX_W-1:0]   free_idx,
    output logic [RS_SIZE-1:0] busy,
    output logic [RS_SIZE-1:0] alloc_oh,
    output logic [RS_SIZE-1:0] free_oh,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               err
);
    rs_mask_t alloc_mask, free_mask;
    logic     alloc_in_range, free_in_range;
    logic     alloc_ok, free_ok, same_slot;

    rs_mask_t busy_reg, busy_next;
    rs_mask_t alloc_oh_reg, alloc_oh_next;
    rs_mask_t free_oh_reg, free_oh_next;
    rs_cnt_t  count_reg, count_next;
    logic     err_reg, err_next;

    binary_to_onehot_RS #(.N(RS_SIZE)) u_alloc_dec (
        .bin      (alloc_idx),
        .oh       (alloc_mask),
        .in_range (alloc_in_range)
    );

    binary_to_onehot_RS #(.N(RS_SIZE)) u_free_dec (
        .bin      (free_idx),
        .oh       (free_mask),
        .in_range (free_in_range)
    );

    // A slot freed this cycle may be re-allocated in the same cycle.
    assign free_ok   = free_en && free_in_range && (|(free_mask & busy_reg));
    assign same_slot = free_ok && (free_idx == alloc_idx);
    assign alloc_ok  = alloc_en && alloc_in_range && (!(|(alloc_mask & busy_reg)) || same_slot);

    always_comb begin
        busy_next     = busy_reg;
        alloc_oh_next = '0;
        free_oh_next  = '0;
        count_next    = count_reg;
        err_next      = err_reg;
        if (flush) begin
            busy_next  = '0;
            count_next = '0;
        end else begin
            alloc_oh_next = alloc_ok ? alloc_mask : '0;
            free_oh_next  = free_ok  ? free_mask  : '0;
            busy_next     = (busy_reg & ~free_oh_next) | alloc_oh_next;
            count_next    = count_reg + CNT_W'(alloc_ok) - CNT_W'(free_ok);
            err_next      = err_reg | (alloc_en && !alloc_ok) | (free_en && !free_ok);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg     <= '0;
            alloc_oh_reg <= '0;
            free_oh_reg  <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            busy_reg     <= busy_next;
            alloc_oh_reg <= alloc_oh_next;
            free_oh_reg  <= free_oh_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
        end
    end

    assign busy     = busy_reg;
    assign alloc_oh = alloc_oh_reg;
    assign free_oh  = free_oh_reg;
    assign count    = count_reg;
    assign err      = err_reg;
    assign full     = (count_reg == CNT_W'(RS_SIZE));
    assign empty    = (count_reg == '0);

    a_count_matches: assert property (@(posedge clock) disable iff (!reset_n)
        count_reg == CNT_W'($countones(busy_reg)));
    a_alloc_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(alloc_oh_reg));
    a_free_onehot:  assert property (@(posedge clock) disable iff (!reset_n) $onehot0(free_oh_reg));
endmodule

// File: tb/tb_rs_slot_tracker.sv
// Directed bench for rs_slot_tracker: fill/drain, round-trip, same-index, errors, flush, async reset.
module tb_rs_slot_tracker;
    import rs_slot_tracker_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             alloc_en;
    logic [IDX_W-1:0] alloc_idx;
    logic             free_en;
    logic [IDX_W-1:0] free_idx;
    logic [31:0]      busy, alloc_oh, free_oh;
    logic [CNT_W-1:0] count;
    logic             full, empty, err;

    int checks = 0;
    int failures = 0;

    rs_slot_tracker dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .free_en   (free_en),
        .free_idx  (free_idx),
        .busy      (busy),
        .alloc_oh  (alloc_oh),
        .free_oh   (free_oh),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Reference one-hot to binary encoder (onehot_to_binary_RS behaviour); -1 when no bit set.
    function automatic int encode(input logic [31:0] oh);
        int r = -1;
        for (int b = 0; b < 32; b++) if (oh[b]) r = b;
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        flush = 1'b0; alloc_en = 1'b0; free_en = 1'b0;
        alloc_idx = '0; free_idx = '0;
    endtask

    task automatic do_alloc(input int idx);
        idle(); alloc_en = 1'b1; alloc_idx = IDX_W'(idx);
        step();
        idle();
    endtask

    task automatic test_reset_state();
        checks++;
        if (busy !== 32'h0 || count !== '0 || alloc_oh !== 32'h0 || free_oh !== 32'h0 ||
            err !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state busy=%h count=%0d aoh=%h foh=%h err=%b empty=%b full=%b expected all 0, empty=1",
                     busy, count, alloc_oh, free_oh, err, empty, full);
        end
        $display("reset_state busy=%h count=%0d empty=%b", busy, count, empty);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp_oh;
            exp_oh = 32'h1 << i;
            do_alloc(i);
            checks++;
            if (alloc_oh !== exp_oh || count !== CNT_W'(i + 1) || free_oh !== 32'h0) begin
                failures++;
                $display("FAIL fill[%0d] alloc_oh=%h count=%0d free_oh=%h expected %h %0d 0",
                         i, alloc_oh, count, free_oh, exp_oh, i + 1);
            end
            checks++;
            if (encode(alloc_oh) !== i) begin
                failures++;
                $display("FAIL round_trip[%0d] got=%0d expected=%0d", i, encode(alloc_oh), i);
            end
            $display("alloc idx=%0d alloc_oh=%h count=%0d", i, alloc_oh, count);
        end
        checks++;
        if (busy !== 32'hFFFF_FFFF || count !== CNT_W'(32) || full !== 1'b1 || empty !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL full_state busy=%h count=%0d full=%b empty=%b err=%b expected ffffffff 32 1 0 0",
                     busy, count, full, empty, err);
        end
        for (int i = 31; i >= 0; i--) begin
            logic [31:0] exp_oh;
            exp_oh = 32'h1 << i;
            idle(); free_en = 1'b1; free_idx = IDX_W'(i);
            step();
            idle();
            checks++;
            if (free_oh !== exp_oh || count !== CNT_W'(i) || alloc_oh !== 32'h0) begin
                failures++;
                $display("FAIL drain[%0d] free_oh=%h count=%0d alloc_oh=%h expected %h %0d 0",
                         i, free_oh, count, alloc_oh, exp_oh, i);
            end
            $display("free idx=%0d free_oh=%h count=%0d", i, free_oh, count);
        end
        checks++;
        if (busy !== 32'h0 || empty !== 1'b1 || err !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL drained busy=%h empty=%b err=%b full=%b expected 0 1 0 0", busy, empty, err, full);
        end
        step();
        checks++;
        if (alloc_oh !== 32'h0 || free_oh !== 32'h0) begin
            failures++;
            $display("FAIL oh_one_cycle alloc_oh=%h free_oh=%h expected 0 0", alloc_oh, free_oh);
        end
    endtask

    task automatic test_same_index();
        do_alloc(7);
        idle();
        alloc_en = 1'b1; alloc_idx = 5'd7; free_en = 1'b1; free_idx = 5'd7;
        step();
        idle();
        checks++;
        if (busy !== 32'h80 || count !== CNT_W'(1) || alloc_oh !== 32'h80 || free_oh !== 32'h80 || err !== 1'b0) begin
            failures++;
            $display("FAIL same_index busy=%h count=%0d aoh=%h foh=%h err=%b expected 80 1 80 80 0",
                     busy, count, alloc_oh, free_oh, err);
        end
        $display("same_index busy=%h count=%0d aoh=%h foh=%h", busy, count, alloc_oh, free_oh);
    endtask

    task automatic test_errors();
        do_alloc(3);
        checks++;
        if (busy !== 32'h88 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_pre busy=%h err=%b expected 88 0", busy, err);
        end
        do_alloc(3);
        checks++;
        if (busy !== 32'h88 || count !== CNT_W'(2) || alloc_oh !== 32'h0 || err !== 1'b1) begin
            failures++;
            $display("FAIL alloc_busy busy=%h count=%0d aoh=%h err=%b expected 88 2 0 1", busy, count, alloc_oh, err);
        end
        $display("alloc_busy idx=3 busy=%h err=%b", busy, err);
        idle(); free_en = 1'b1; free_idx = 5'd9;
        step();
        idle();
        checks++;
        if (busy !== 32'h88 || count !== CNT_W'(2) || free_oh !== 32'h0 || err !== 1'b1) begin
            failures++;
            $display("FAIL free_idle busy=%h count=%0d foh=%h err=%b expected 88 2 0 1", busy, count, free_oh, err);
        end
        $display("free_idle idx=9 busy=%h err=%b", busy, err);
        // Legal traffic afterwards must not clear the sticky flag.
        do_alloc(4);
        checks++;
        if (err !== 1'b1 || busy !== 32'h98) begin
            failures++;
            $display("FAIL err_sticky err=%b busy=%h expected 1 98", err, busy);
        end
    endtask

    task automatic test_flush();
        // Slots 3,4,7 busy; add 9 more (10..18) for count=12.
        for (int i = 10; i < 19; i++) do_alloc(i);
        checks++;
        if (count !== CNT_W'(12)) begin
            failures++;
            $display("FAIL pre_flush count=%0d expected 12", count);
        end
        idle(); flush = 1'b1; alloc_en = 1'b1; alloc_idx = 5'd20;
        step();
        idle();
        checks++;
        if (busy !== 32'h0 || count !== '0 || alloc_oh !== 32'h0 || free_oh !== 32'h0 ||
            empty !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL flush busy=%h count=%0d aoh=%h foh=%h empty=%b err=%b expected 0 0 0 0 1 1",
                     busy, count, alloc_oh, free_oh, empty, err);
        end
        $display("flush busy=%h count=%0d err=%b", busy, count, err);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 32; i++) do_alloc(i);
        checks++;
        if (busy !== 32'hFFFF_FFFF || full !== 1'b1) begin
            failures++;
            $display("FAIL refill busy=%h full=%b expected ffffffff 1", busy, full);
        end
        // Assert reset between clock edges; outputs must clear without a clock.
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 32'h0 || count !== '0 || alloc_oh !== 32'h0 || free_oh !== 32'h0 ||
            err !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset busy=%h count=%0d aoh=%h foh=%h err=%b empty=%b full=%b expected all 0, empty=1",
                     busy, count, alloc_oh, free_oh, err, empty, full);
        end
        $display("async_reset busy=%h count=%0d err=%b", busy, count, err);
        @(negedge clock);
        reset_n = 1'b1;
        do_alloc(5);
        checks++;
        if (busy !== 32'h20 || count !== CNT_W'(1) || err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset busy=%h count=%0d err=%b expected 20 1 0", busy, count, err);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        step();
        test_reset_state();
        test_fill_drain();
        test_same_index();
        test_errors();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
